reset_sequencer: RTL and testbench

- Consumes the synchronized chip reset (async assert, sync deassert) and releases NUM_STAGES downstream domain resets one at a time, in index order.
- Each stage is released after a programmable gap and, optionally, after the previous stage acknowledges that it is ready.
- Supports a software-requested re-reset once the sequence has completed.
- Sits directly downstream of the reset synchronizer flops and fans out to the subsystem reset inputs.

---
 rtl/reset_sequencer.sv | 162 ++++++++++++++++
 tb/tb_reset_sequencer.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/reset_sequencer.sv
// Reset sequencer: releases NUM_STAGES downstream resets one at a time in
// index order, with a fixed gap before each release and an optional bounded
// wait for the previous stage's ready acknowledge. Supports a software
// re-reset once the sequence has completed. Every output comes straight
// from a flop.
module reset_sequencer #(
    parameter int NUM_STAGES    = 4,
    parameter int STAGE_DELAY   = 16,
    parameter int ACK_TIMEOUT   = 64,
    parameter int SW_RST_CYCLES = 8,
    parameter int CNT_WIDTH     = 8
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  sw_rst_req,
    input  logic [NUM_STAGES-1:0] stage_ack,
    output logic [NUM_STAGES-1:0] rst_n_out,
    output logic                  seq_done,
    output logic                  busy,
    output logic                  ack_timeout_err
);

    localparam int IDX_W = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;
    localparam int MAX_A = (STAGE_DELAY > ACK_TIMEOUT) ? STAGE_DELAY : ACK_TIMEOUT;
    localparam int MAX_V = (MAX_A > SW_RST_CYCLES) ? MAX_A : SW_RST_CYCLES;

    // Terminal counts; ACK_TIMEOUT=0 never reaches WAIT_ACK, so its value is moot.
    localparam logic [CNT_WIDTH-1:0] DELAY_LAST = CNT_WIDTH'(STAGE_DELAY - 1);
    localparam logic [CNT_WIDTH-1:0] ACK_LAST   = CNT_WIDTH'((ACK_TIMEOUT > 0) ? ACK_TIMEOUT - 1 : 0);
    localparam logic [CNT_WIDTH-1:0] SW_LAST    = CNT_WIDTH'(SW_RST_CYCLES - 1);
    localparam logic [IDX_W-1:0]     IDX_LAST   = IDX_W'(NUM_STAGES - 1);

    generate
        if (NUM_STAGES < 1 || NUM_STAGES > 16) begin : g_bad_stages
            $error("reset_sequencer: NUM_STAGES must be 1..16");
        end
        if (STAGE_DELAY < 1 || SW_RST_CYCLES < 1 || ACK_TIMEOUT < 0) begin : g_bad_timing
            $error("reset_sequencer: STAGE_DELAY and SW_RST_CYCLES must be >= 1");
        end
        if (CNT_WIDTH < 1 || CNT_WIDTH > 31 || MAX_V > (2 ** CNT_WIDTH) - 1) begin : g_bad_cnt
            $error("reset_sequencer: CNT_WIDTH too narrow for the configured delays");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_DELAY,
        S_WAIT_ACK,
        S_DONE,
        S_SWRST
    } state_t;

    state_t                  state_q, state_d;
    logic [CNT_WIDTH-1:0]    cnt_q, cnt_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [NUM_STAGES-1:0]   rst_q, rst_d;
    logic                    done_q, done_d;
    logic                    busy_q, busy_d;
    logic                    err_q, err_d;

    // State and output registers; reset forces every output to its safe value.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_DELAY;
            cnt_q   <= '0;
            idx_q   <= '0;
            rst_q   <= '0;
            done_q  <= 1'b0;
            busy_q  <= 1'b1;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            rst_q   <= rst_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
            err_q   <= err_d;
        end
    end

    // Next-state logic; "advance" is either the move to DONE or to the next stage's DELAY.
    always_comb begin
        logic advance;
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        rst_d   = rst_q;
        done_d  = done_q;
        err_d   = err_q;
        advance = 1'b0;

        unique case (state_q)
            S_DELAY: begin
                if (cnt_q == DELAY_LAST) begin
                    rst_d[idx_q] = 1'b1;
                    cnt_d        = '0;
                    if (ACK_TIMEOUT == 0) begin
                        advance = 1'b1;
                    end else begin
                        state_d = S_WAIT_ACK;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_WIDTH'(1);
                end
            end
            S_WAIT_ACK: begin
                if (stage_ack[idx_q]) begin
                    advance = 1'b1;
                end else if (cnt_q == ACK_LAST) begin
                    err_d   = 1'b1;
                    advance = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_WIDTH'(1);
                end
            end
            S_DONE: begin
                if (sw_rst_req) begin
                    rst_d   = '0;
                    done_d  = 1'b0;
                    cnt_d   = '0;
                    state_d = S_SWRST;
                end
            end
            S_SWRST: begin
                if (cnt_q == SW_LAST) begin
                    idx_d   = '0;
                    cnt_d   = '0;
                    err_d   = 1'b0;
                    state_d = S_DELAY;
                end else begin
                    cnt_d = cnt_q + CNT_WIDTH'(1);
                end
            end
            default: begin
                state_d = S_DELAY;
            end
        endcase

        if (advance) begin
            cnt_d = '0;
            if (idx_q == IDX_LAST) begin
                state_d = S_DONE;
                done_d  = 1'b1;
            end else begin
                idx_d   = idx_q + IDX_W'(1);
                state_d = S_DELAY;
            end
        end

        busy_d = (state_d != S_DONE);
    end

    // Released bits must stay contiguous from bit 0 upward.
    assert property (@(posedge clk) disable iff (!reset_n)
                     ((rst_q & (rst_q + NUM_STAGES'(1))) == '0));

    assign rst_n_out       = rst_q;
    assign seq_done        = done_q;
    assign busy            = busy_q;
    assign ack_timeout_err = err_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Bench for reset_sequencer: three instances (ack wait with long timeout,
// ack wait with short timeout, no ack wait) driven from a vector table plus
// hand-written sequences for software re-reset and async reset assertion.
module tb_reset_sequencer;

    logic       clk = 1'b0;
    logic       rn  [3];
    logic       sw  [3];
    logic [2:0] ack [3];
    logic [2:0] ro  [3];
    logic       dn  [3];
    logic       bz  [3];
    logic       er  [3];

    int errors = 0;
    int checks = 0;
    int cur    = 0;

    always #5 clk = ~clk;

    reset_sequencer #(.NUM_STAGES(3), .STAGE_DELAY(4), .ACK_TIMEOUT(64),
                      .SW_RST_CYCLES(8), .CNT_WIDTH(8)) u_a (
        .clk(clk), .reset_n(rn[0]), .sw_rst_req(sw[0]), .stage_ack(ack[0]),
        .rst_n_out(ro[0]), .seq_done(dn[0]), .busy(bz[0]), .ack_timeout_err(er[0]));

    reset_sequencer #(.NUM_STAGES(3), .STAGE_DELAY(4), .ACK_TIMEOUT(6),
                      .SW_RST_CYCLES(8), .CNT_WIDTH(8)) u_b (
        .clk(clk), .reset_n(rn[1]), .sw_rst_req(sw[1]), .stage_ack(ack[1]),
        .rst_n_out(ro[1]), .seq_done(dn[1]), .busy(bz[1]), .ack_timeout_err(er[1]));

    reset_sequencer #(.NUM_STAGES(3), .STAGE_DELAY(4), .ACK_TIMEOUT(0),
                      .SW_RST_CYCLES(8), .CNT_WIDTH(8)) u_c (
        .clk(clk), .reset_n(rn[2]), .sw_rst_req(sw[2]), .stage_ack(ack[2]),
        .rst_n_out(ro[2]), .seq_done(dn[2]), .busy(bz[2]), .ack_timeout_err(er[2]));

    typedef struct {
        int         sel;
        int         edge_n;   // 0 = apply reset, check, then release
        logic [2:0] ack;
        logic [5:0] exp;      // {rst_n_out, seq_done, busy, ack_timeout_err}
        int         id;
    } vec_t;

    vec_t tbl[$];

    function automatic logic [5:0] E(logic [2:0] r, logic d, logic b, logic e);
        return {r, d, b, e};
    endfunction

    function automatic void add(int sel, int e, logic [2:0] a, logic [5:0] x, int id);
        vec_t v;
        v.sel = sel; v.edge_n = e; v.ack = a; v.exp = x; v.id = id;
        tbl.push_back(v);
    endfunction

    function automatic logic [5:0] obs(int s);
        return {ro[s], dn[s], bz[s], er[s]};
    endfunction

    task automatic check(string name, int s, logic [5:0] exp);
        logic [5:0] got;
        got = obs(s);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s dut=%0d edge=%0d got rst=%b done=%b busy=%b err=%b required rst=%b done=%b busy=%b err=%b",
                     name, s, cur, got[5:3], got[2], got[1], got[0], exp[5:3], exp[2], exp[1], exp[0]);
        end
    endtask

    task automatic goto(int e);
        while (cur < e) begin
            @(posedge clk);
            cur++;
        end
        #1;
    endtask

    task automatic do_reset(int s, logic [5:0] exp, int id);
        rn[s] = 1'b0;
        @(posedge clk);
        #1;
        check($sformatf("reset_state_t%0d", id), s, exp);
        @(negedge clk);
        rn[s] = 1'b1;
        cur = 0;
    endtask

    // Released bits must always be contiguous from bit 0.
    always @(negedge clk) begin
        for (int d = 0; d < 3; d++) begin
            if (rn[d] === 1'b1) begin
                checks++;
                if ((ro[d] & (ro[d] + 3'd1)) != 3'd0) begin
                    errors++;
                    $display("FAIL monotonic dut=%0d got rst=%b required contiguous ones from bit0", d, ro[d]);
                end
            end
        end
    end

    initial begin
        for (int d = 0; d < 3; d++) begin
            rn[d] = 1'b0; sw[d] = 1'b0; ack[d] = 3'b000;
        end

        // Test 1: acks high, releases at edges 4/9/14, done after 15
        add(0, 0,  3'b111, E(3'b000,0,1,0), 1);
        add(0, 3,  3'b111, E(3'b000,0,1,0), 1);
        add(0, 4,  3'b111, E(3'b001,0,1,0), 1);
        add(0, 8,  3'b111, E(3'b001,0,1,0), 1);
        add(0, 9,  3'b111, E(3'b011,0,1,0), 1);
        add(0, 13, 3'b111, E(3'b011,0,1,0), 1);
        add(0, 14, 3'b111, E(3'b111,0,1,0), 1);
        add(0, 15, 3'b111, E(3'b111,1,0,0), 1);
        // Test 2: stage_ack[1] low through edge 20
        add(0, 0,  3'b101, E(3'b000,0,1,0), 2);
        add(0, 4,  3'b101, E(3'b001,0,1,0), 2);
        add(0, 9,  3'b101, E(3'b011,0,1,0), 2);
        add(0, 20, 3'b101, E(3'b011,0,1,0), 2);
        add(0, 21, 3'b111, E(3'b011,0,1,0), 2);
        add(0, 24, 3'b111, E(3'b011,0,1,0), 2);
        add(0, 25, 3'b111, E(3'b111,0,1,0), 2);
        add(0, 26, 3'b111, E(3'b111,1,0,0), 2);
        // Test 3: no ack wait, releases every 4 edges
        add(2, 0,  3'b000, E(3'b000,0,1,0), 3);
        add(2, 3,  3'b000, E(3'b000,0,1,0), 3);
        add(2, 4,  3'b000, E(3'b001,0,1,0), 3);
        add(2, 7,  3'b000, E(3'b001,0,1,0), 3);
        add(2, 8,  3'b000, E(3'b011,0,1,0), 3);
        add(2, 11, 3'b000, E(3'b011,0,1,0), 3);
        add(2, 12, 3'b000, E(3'b111,1,0,0), 3);
        // Test 4: ACK_TIMEOUT=6 with no acks, releases 10 edges apart
        add(1, 0,  3'b000, E(3'b000,0,1,0), 4);
        add(1, 4,  3'b000, E(3'b001,0,1,0), 4);
        add(1, 9,  3'b000, E(3'b001,0,1,0), 4);
        add(1, 10, 3'b000, E(3'b001,0,1,1), 4);
        add(1, 13, 3'b000, E(3'b001,0,1,1), 4);
        add(1, 14, 3'b000, E(3'b011,0,1,1), 4);
        add(1, 23, 3'b000, E(3'b011,0,1,1), 4);
        add(1, 24, 3'b000, E(3'b111,0,1,1), 4);
        add(1, 29, 3'b000, E(3'b111,0,1,1), 4);
        add(1, 30, 3'b000, E(3'b111,1,0,1), 4);

        foreach (tbl[i]) begin
            ack[tbl[i].sel] = tbl[i].ack;
            if (tbl[i].edge_n == 0) begin
                do_reset(tbl[i].sel, tbl[i].exp, tbl[i].id);
            end else begin
                goto(tbl[i].edge_n);
                check($sformatf("vec_t%0d_e%0d", tbl[i].id, tbl[i].edge_n), tbl[i].sel, tbl[i].exp);
            end
        end

        // Software re-reset on instance B (DONE at edge 30, error flag set)
        sw[1] = 1'b1;
        goto(31);
        sw[1] = 1'b0;
        check("swrst_enter", 1, E(3'b000,0,1,1));
        goto(34);
        sw[1] = 1'b1;                      // ignored while in SWRST
        goto(35);
        sw[1] = 1'b0;
        goto(38);
        check("swrst_hold", 1, E(3'b000,0,1,1));
        goto(39);
        check("swrst_exit", 1, E(3'b000,0,1,0));
        goto(40);
        sw[1] = 1'b1;                      // ignored while in DELAY
        goto(41);
        sw[1] = 1'b0;
        goto(42);
        check("swrst_pre_release", 1, E(3'b000,0,1,0));
        goto(43);
        check("swrst_release0", 1, E(3'b001,0,1,0));
        goto(53);
        check("swrst_release1", 1, E(3'b011,0,1,1));

        // Async reset assertion mid-sequence on instance A
        ack[0] = 3'b111;
        do_reset(0, E(3'b000,0,1,0), 5);
        goto(11);
        check("async_pre", 0, E(3'b011,0,1,0));
        #2;
        rn[0] = 1'b0;
        #1;
        check("async_assert", 0, E(3'b000,0,1,0));
        @(negedge clk);
        rn[0] = 1'b1;
        cur = 0;
        goto(3);
        check("async_restart_e3", 0, E(3'b000,0,1,0));
        goto(4);
        check("async_restart_e4", 0, E(3'b001,0,1,0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
